// File: rtl/dp_ram_seq.sv
// dp_ram_seq: single-clock true dual-port RAM with per-port auto-increment
// address counters, selectable read latency and a post-reset zero-fill.
module dp_ram_seq #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 9,
   parameter int RD_LAT    = 1,
   parameter int RDW_MODE  = 0,
   parameter int INIT_ZERO = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              wea,
   input  logic              auto_a,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] dina,
   output logic [DATA_W-1:0] douta,
   output logic              vlda,
   input  logic              enb,
   input  logic              web,
   input  logic              auto_b,
   input  logic [ADDR_W-1:0] addrb,
   input  logic [DATA_W-1:0] dinb,
   output logic [DATA_W-1:0] doutb,
   output logic              vldb,
   output logic              busy,
   output logic              coll
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] init_addr_reg;
   logic              run;
   logic              init_we;
   logic              coll_reg;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [1:0]        en_p;
   logic [1:0]        we_p;
   logic [1:0]        auto_p;
   logic [1:0]        acc_p;
   logic [1:0]        wr_p;
   logic [ADDR_W-1:0] addr_p [2];
   logic [ADDR_W-1:0] eff_p  [2];
   logic [DATA_W-1:0] din_p  [2];
   logic [DATA_W-1:0] dout_p [2];
   logic              vld_p  [2];

   logic              mem_wa_en;
   logic [ADDR_W-1:0] mem_wa_addr;
   logic [DATA_W-1:0] mem_wa_data;

   assign en_p      = {enb, ena};
   assign we_p      = {web, wea};
   assign auto_p    = {auto_b, auto_a};
   assign addr_p[0] = addra;
   assign addr_p[1] = addrb;
   assign din_p[0]  = dina;
   assign din_p[1]  = dinb;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= (INIT_ZERO != 0) ? S_INIT : S_RUN;
         init_addr_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_INIT) begin
            init_addr_reg <= init_addr_reg + 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_INIT:  if (init_addr_reg == {ADDR_W{1'b1}}) state_next = S_RUN;
         default: state_next = state_reg;
      endcase
   end

   // rst_n gating keeps the array untouched while reset is held low.
   always_comb begin
      busy    = (state_reg == S_INIT);
      run     = (state_reg == S_RUN) && rst_n;
      init_we = (state_reg == S_INIT) && rst_n;
   end

   assign acc_p = en_p & {2{run}};
   assign wr_p  = acc_p & we_p;

   // The zero-fill borrows the port A write path; port A is ignored then anyway.
   assign mem_wa_en   = init_we | wr_p[0];
   assign mem_wa_addr = init_we ? init_addr_reg : eff_p[0];
   assign mem_wa_data = init_we ? '0 : din_p[0];

   // Port A is written last so it wins a same-address write collision.
   always_ff @(posedge clk) begin
      if (wr_p[1]) mem[eff_p[1]] <= din_p[1];
      if (mem_wa_en) mem[mem_wa_addr] <= mem_wa_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coll_reg <= 1'b0;
      end else begin
         coll_reg <= wr_p[0] && wr_p[1] && (eff_p[0] == eff_p[1]);
      end
   end

   assign coll = coll_reg;

   // ---------------- per-port address counter and read pipeline ----------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [ADDR_W-1:0] cnt_reg;
         logic [DATA_W-1:0] rd1_reg;
         logic              vld1_reg;

         assign eff_p[gi] = auto_p[gi] ? cnt_reg : addr_p[gi];

         // Explicit and auto accesses both leave the counter one past the address used.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg  <= '0;
               rd1_reg  <= '0;
               vld1_reg <= 1'b0;
            end else begin
               vld1_reg <= acc_p[gi];
               if (acc_p[gi]) begin
                  cnt_reg <= eff_p[gi] + 1'b1;
                  rd1_reg <= (RDW_MODE == 1 && we_p[gi]) ? din_p[gi] : mem[eff_p[gi]];
               end
            end
         end

         if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] rd2_reg;
            logic              vld2_reg;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  rd2_reg  <= '0;
                  vld2_reg <= 1'b0;
               end else begin
                  vld2_reg <= vld1_reg;
                  if (vld1_reg) rd2_reg <= rd1_reg;
               end
            end

            assign dout_p[gi] = rd2_reg;
            assign vld_p[gi]  = vld2_reg;
         end else begin : g_lat1
            assign dout_p[gi] = rd1_reg;
            assign vld_p[gi]  = vld1_reg;
         end
      end
   endgenerate

   assign douta = dout_p[0];
   assign vlda  = vld_p[0];
   assign doutb = dout_p[1];
   assign vldb  = vld_p[1];

endmodule

// File: tb/tb_dp_ram_seq.sv
// tb_dp_ram_seq: drives two dp_ram_seq instances (RD_LAT=1/read-first and
// RD_LAT=2/write-first) with shared stimulus, checked against an array model.
module tb_dp_ram_seq;
   localparam int AW    = 9;
   localparam int DW    = 8;
   localparam int DEPTH = 512;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ena, wea, auto_a, enb, web, auto_b;
   logic [AW-1:0] addra, addrb;
   logic [DW-1:0] dina, dinb;
   logic [DW-1:0] douta1, doutb1, douta2, doutb2;
   logic          vlda1, vldb1, vlda2, vldb2;
   logic          busy1, busy2, coll1, coll2;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   logic [DW-1:0] ref_mem [DEPTH];
   int            init_left;
   logic [AW-1:0] ref_cnt [2];
   logic [DW-1:0] e1_d [2];
   logic          e1_v [2];
   logic [DW-1:0] s1_d [2];
   logic          s1_v [2];
   logic [DW-1:0] e2_d [2];
   logic          e2_v [2];
   logic          e_coll;

   always #5 clk = ~clk;

   dp_ram_seq #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .RDW_MODE(0), .INIT_ZERO(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .ena(ena), .wea(wea), .auto_a(auto_a), .addra(addra), .dina(dina), .douta(douta1), .vlda(vlda1),
      .enb(enb), .web(web), .auto_b(auto_b), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .vldb(vldb1),
      .busy(busy1), .coll(coll1)
   );

   dp_ram_seq #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .RDW_MODE(1), .INIT_ZERO(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .ena(ena), .wea(wea), .auto_a(auto_a), .addra(addra), .dina(dina), .douta(douta2), .vlda(vlda2),
      .enb(enb), .web(web), .auto_b(auto_b), .addrb(addrb), .dinb(dinb), .doutb(doutb2), .vldb(vldb2),
      .busy(busy2), .coll(coll2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      init_left = DEPTH;
      for (int p = 0; p < 2; p++) begin
         ref_cnt[p] = '0;
         e1_d[p] = '0; e1_v[p] = 1'b0;
         s1_d[p] = '0; s1_v[p] = 1'b0;
         e2_d[p] = '0; e2_v[p] = 1'b0;
      end
      e_coll = 1'b0;
   endtask

   // One rising edge of the reference: fill, then reads (old data), then writes.
   task automatic model_edge();
      logic          en [2], we [2], au [2], acc [2], wr [2];
      logic [AW-1:0] ad [2], eff [2];
      logic [DW-1:0] di [2], old [2];
      logic          busy_now;
      en[0] = ena; we[0] = wea; au[0] = auto_a; ad[0] = addra; di[0] = dina;
      en[1] = enb; we[1] = web; au[1] = auto_b; ad[1] = addrb; di[1] = dinb;
      busy_now = (init_left > 0);
      if (busy_now) begin
         ref_mem[DEPTH - init_left] = '0;
         init_left--;
      end
      for (int p = 0; p < 2; p++) begin
         acc[p] = en[p] && !busy_now;
         eff[p] = au[p] ? ref_cnt[p] : ad[p];
         old[p] = ref_mem[eff[p]];
         wr[p]  = acc[p] && we[p];
      end
      e_coll = wr[0] && wr[1] && (eff[0] == eff[1]);
      if (wr[1]) ref_mem[eff[1]] = di[1];
      if (wr[0]) ref_mem[eff[0]] = di[0];
      for (int p = 0; p < 2; p++) begin
         if (acc[p]) ref_cnt[p] = eff[p] + 1'b1;
         e1_v[p] = acc[p];
         if (acc[p]) e1_d[p] = old[p];
         e2_v[p] = s1_v[p];
         if (s1_v[p]) e2_d[p] = s1_d[p];
         s1_v[p] = acc[p];
         if (acc[p]) s1_d[p] = we[p] ? di[p] : old[p];
      end
   endtask

   task automatic check_outputs();
      chk("douta1", douta1, e1_d[0]); chk("vlda1", vlda1, e1_v[0]);
      chk("doutb1", doutb1, e1_d[1]); chk("vldb1", vldb1, e1_v[1]);
      chk("douta2", douta2, e2_d[0]); chk("vlda2", vlda2, e2_v[0]);
      chk("doutb2", doutb2, e2_d[1]); chk("vldb2", vldb2, e2_v[1]);
      chk("busy1", busy1, init_left > 0); chk("busy2", busy2, init_left > 0);
      chk("coll1", coll1, e_coll); chk("coll2", coll2, e_coll);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
      if (ena || enb)
         $display("txn t=%0t A en=%0b we=%0b auto=%0b addr=%03h din=%02h | B en=%0b we=%0b auto=%0b addr=%03h din=%02h | busy=%0b",
                  $time, ena, wea, auto_a, addra, dina, enb, web, auto_b, addrb, dinb, busy1);
   endtask

   task automatic set_a(input logic en, input logic we, input logic au, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      ena = en; wea = we; auto_a = au; addra = ad; dina = d;
   endtask

   task automatic set_b(input logic en, input logic we, input logic au, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      enb = en; web = we; auto_b = au; addrb = ad; dinb = d;
   endtask

   initial begin
      int            nb;
      logic [DW-1:0] stream [8];

      rst_n = 1'b0;
      set_a(0, 0, 0, '0, '0);
      set_b(0, 0, 0, '0, '0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      model_reset();
      #2;
      check_outputs();
      #20;
      rst_n = 1'b1;

      // zero-fill length
      nb = 0;
      for (int i = 0; i < DEPTH + 4; i++) begin
         if (busy1) nb++;
         step();
      end
      chk("init_len", nb, DEPTH);

      // reads after fill
      set_a(1, 0, 0, 9'd0, '0); set_b(1, 0, 0, 9'd255, '0); step();
      chk("rd_000", douta1, 8'h00); chk("rd_000_vld", vlda1, 1'b1); chk("rd_0ff", doutb1, 8'h00);
      set_a(1, 0, 0, 9'd511, '0); set_b(0, 0, 0, '0, '0); step();
      chk("rd_1ff", douta1, 8'h00);
      set_a(0, 0, 0, '0, '0); step();

      // auto write burst across the wrap
      set_a(1, 1, 0, 9'h1FE, 8'hA5); step();
      set_a(1, 1, 1, 9'h000, 8'h01); step();
      set_a(1, 1, 1, 9'h000, 8'h02); step();
      set_a(1, 1, 1, 9'h000, 8'h03); step();
      set_a(1, 0, 0, 9'h1FE, '0); set_b(1, 0, 0, 9'h1FF, '0); step();
      chk("wrap_1fe", douta1, 8'hA5); chk("wrap_1ff", doutb1, 8'h01);
      set_a(0, 0, 0, '0, '0); set_b(1, 0, 0, 9'h000, '0); step();
      chk("wrap_000", doutb1, 8'h02);
      set_b(1, 0, 0, 9'h001, '0); step();
      chk("wrap_001", doutb1, 8'h03);
      set_b(0, 0, 0, '0, '0); step();

      // write-write collision
      set_a(1, 1, 0, 9'h010, 8'h11); set_b(1, 1, 0, 9'h010, 8'h22); step();
      chk("coll_pulse", coll1, 1'b1);
      set_a(0, 0, 0, '0, '0); set_b(0, 0, 0, '0, '0); step();
      chk("coll_end", coll1, 1'b0);
      set_a(1, 0, 0, 9'h010, '0); step();
      chk("coll_data", douta1, 8'h11);
      set_a(0, 0, 0, '0, '0); step();

      // read-during-write
      set_a(1, 1, 0, 9'h020, 8'h33); step();
      set_a(1, 1, 0, 9'h020, 8'h44); set_b(1, 0, 0, 9'h020, '0); step();
      chk("rdw_rf_a", douta1, 8'h33); chk("rdw_rf_b", doutb1, 8'h33);
      set_a(0, 0, 0, '0, '0); set_b(0, 0, 0, '0, '0); step();
      chk("rdw_wf_a", douta2, 8'h44); chk("rdw_wf_b", doutb2, 8'h33);
      step();

      // RD_LAT=2 streaming: preload 0x40..0x47 then read back-to-back
      for (int i = 0; i < 8; i++) begin
         stream[i] = DW'($urandom);
         set_b(1, 1, (i != 0), 9'h040, stream[i]);
         step();
      end
      set_b(0, 0, 0, '0, '0); step();
      set_a(1, 0, 0, 9'h040, '0); step();
      chk("strm_lead", vlda2, 1'b0);
      for (int i = 0; i < 7; i++) begin
         set_a(1, 0, 1, '0, '0); step();
         chk("strm_vld", vlda2, 1'b1); chk("strm_data", douta2, stream[i]);
      end
      set_a(0, 0, 0, '0, '0); step();
      chk("strm_vld", vlda2, 1'b1); chk("strm_data", douta2, stream[7]);
      step();
      chk("strm_tail", vlda2, 1'b0);

      // randomized traffic on a small window to provoke collisions
      for (int i = 0; i < 300; i++) begin
         set_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               AW'($urandom_range(0, 15)), DW'($urandom));
         set_b(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               AW'($urandom_range(0, 15)), DW'($urandom));
         step();
      end

      // reset in the middle of an auto burst
      set_a(1, 0, 1, '0, '0); set_b(1, 1, 1, '0, 8'h5A);
      repeat (3) step();
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_vlda1", vlda1, 1'b0); chk("arst_vldb1", vldb1, 1'b0);
      chk("arst_vlda2", vlda2, 1'b0); chk("arst_vldb2", vldb2, 1'b0);
      chk("arst_douta1", douta1, 8'h00); chk("arst_busy", busy1, 1'b1);
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      nb = 0;
      for (int i = 0; i < DEPTH + 6; i++) begin
         if (busy1) nb++;
         step();
      end
      chk("reinit_len", nb, DEPTH);
      set_a(0, 0, 0, '0, '0); set_b(0, 0, 0, '0, '0);
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
